// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin packet arbiter onto one egress stream, with oversize truncation
module eth_tx_arbiter #(
    parameter int NPORT     = 4,
    parameter int DW        = 32,
    parameter int MAX_WORDS = 384,
    localparam int PW       = $clog2(NPORT),
    localparam int CW       = $clog2(MAX_WORDS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    in_valid,
    input  logic [NPORT*DW-1:0] in_data,
    input  logic [NPORT-1:0]    in_sop,
    input  logic [NPORT-1:0]    in_eop,
    output logic [NPORT-1:0]    in_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic                out_sop,
    output logic                out_eop,
    input  logic                out_ready,
    output logic [PW-1:0]       out_port,
    output logic                busy,
    output logic                err_len
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP} state_t;
    state_t r_state, w_next;
    logic [PW-1:0] r_grant, r_rr_last, w_pick;
    logic [CW-1:0] r_count;
    logic r_err, w_any, w_xfer, w_valid_g, w_eop_g, w_last;
    logic [NPORT-1:0] w_req;
    assign w_req     = in_valid & in_sop;
    assign w_valid_g = in_valid[r_grant];
    assign w_eop_g   = in_eop[r_grant];
    assign w_last    = r_count == CW'(MAX_WORDS - 1);
    assign busy      = r_state != S_IDLE;
    assign err_len   = r_err;
    assign out_port  = r_grant;
    // first requester after the last served port; scanning downward lets the nearest one win
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        for (int k = NPORT; k >= 1; k--) begin
            if (w_req[PW'((int'(r_rr_last) + k) % NPORT)]) begin
                w_pick = PW'((int'(r_rr_last) + k) % NPORT);
                w_any  = 1'b1;
            end
        end
    end
    // next state and the granted port's pass-through / drain handshake
    always_comb begin
        w_next    = r_state;
        in_ready  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        w_xfer    = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = w_any ? S_BUSY : S_IDLE;
            S_BUSY: begin
                out_valid         = w_valid_g;
                out_data          = in_data[r_grant*DW +: DW];
                out_sop           = in_sop[r_grant];
                out_eop           = w_eop_g | (w_valid_g & w_last);
                in_ready[r_grant] = out_ready;
                w_xfer            = w_valid_g & out_ready;
                w_next            = !w_xfer ? S_BUSY : w_eop_g ? S_IDLE : w_last ? S_DROP : S_BUSY;
            end
            S_DROP: begin
                in_ready[r_grant] = 1'b1;
                w_next            = (w_valid_g & w_eop_g) ? S_IDLE : S_DROP;
            end
            default: w_next = S_IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end
    // grant, round-robin pointer, word count and truncation flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant   <= '0;
            r_rr_last <= PW'(NPORT - 1);
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_xfer & ~w_eop_g & w_last;
            if (r_state == S_IDLE && w_any) begin
                r_grant <= w_pick;
                r_count <= '0;
            end
            if (w_xfer) r_count <= r_count + 1'b1;
            if (w_xfer & (w_eop_g | w_last)) r_rr_last <= r_grant;
        end
    end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: scoreboard bench for the egress packet arbiter
module tb_eth_tx_arbiter;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int MW = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NP-1:0] in_valid = '0, in_sop = '0, in_eop = '0, in_ready;
    logic [NP*DW-1:0] in_data = '0;
    logic out_valid, out_sop, out_eop, busy, err_len;
    logic out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [1:0] out_port;
    always #5 clk = ~clk;
    eth_tx_arbiter #(.NPORT(NP), .DW(DW), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop),
        .in_eop(in_eop), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_ready(out_ready), .out_port(out_port),
        .busy(busy), .err_len(err_len)
    );
    typedef struct packed {logic [31:0] d; logic s; logic e;} word_t;
    typedef struct packed {logic [1:0] p; logic [31:0] d; logic s; logic e;} exp_t;
    word_t src_q[NP][$];
    exp_t exp_q[$];
    int n_chk = 0, n_pass = 0, cyc = 0, n_out = 0, n_err = 0, t_eop = -1, t_err = -1, drop_acc = 0;
    logic [63:0] ov_hist, bz_hist;
    logic r1_seen;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    function automatic logic [31:0] wd(input int p, input int k, input int w);
        return 32'(p * 32'h0100_0000 + k * 32'h0001_0000 + w);
    endfunction
    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            in_valid[i] = src_q[i].size() > 0;
            in_data[i*DW +: DW] = src_q[i].size() > 0 ? src_q[i][0].d : '0;
            in_sop[i] = src_q[i].size() > 0 ? src_q[i][0].s : 1'b0;
            in_eop[i] = src_q[i].size() > 0 ? src_q[i][0].e : 1'b0;
        end
    endtask
    task automatic pkt(input int p, input int k, input int n, input int nexp);
        for (int w = 0; w < n; w++) begin
            src_q[p].push_back('{d: wd(p, k, w), s: w == 0, e: w == n - 1});
            if (w < nexp) exp_q.push_back('{p: 2'(p), d: wd(p, k, w), s: w == 0, e: (w == n - 1) || (w == nexp - 1)});
        end
    endtask
    task automatic step();
        logic [NP-1:0] acc;
        exp_t e;
        @(negedge clk);
        acc = in_valid & in_ready;
        if (cyc < 64) begin
            ov_hist[cyc] = out_valid;
            bz_hist[cyc] = busy;
        end
        if (in_ready[1]) r1_seen = 1'b1;
        if (in_ready != '0 && !out_valid) drop_acc++;
        if (err_len) begin
            n_err++;
            t_err = cyc;
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (out_eop) t_eop = cyc;
            if (exp_q.size() == 0) chk("extra_out", out_data, 0);
            else begin
                e = exp_q.pop_front();
                chk("out_port", out_port, e.p);
                chk("out_data", out_data, e.d);
                chk("out_sop", out_sop, e.s);
                chk("out_eop", out_eop, e.e);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) if (acc[i]) void'(src_q[i].pop_front());
        drive();
        cyc++;
    endtask
    function automatic logic done(input logic [NP-1:0] ign);
        logic d = exp_q.size() == 0 && !busy;
        for (int i = 0; i < NP; i++) if (!ign[i] && src_q[i].size() != 0) d = 1'b0;
        return d;
    endfunction
    task automatic run(input string tag, input logic [NP-1:0] ign, input int budget);
        int b = 0;
        while (!done(ign) && b < budget) begin
            step();
            b++;
        end
        chk(tag, done(ign), 1);
    endtask
    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < NP; i++) src_q[i].delete();
        exp_q.delete();
        out_ready = 1'b1;
        drive();
        #1;
        chk("rst_outs", {in_ready, out_valid, out_sop, out_eop, out_port, busy, err_len}, 0);
        chk("rst_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        {cyc, n_out, n_err, drop_acc} = '0;
        t_eop = -1;
        t_err = -1;
        ov_hist = '0;
        bz_hist = '0;
        r1_seen = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int b;
        do_reset();
        pkt(0, 0, 3, 3);
        drive();
        run("s1_done", '0, 20);
        step();
        step();
        chk("s1_valid", ov_hist[5:0], 6'b001110);
        chk("s1_busy", bz_hist[5:0], 6'b001110);
        do_reset();
        pkt(0, 0, 2, 2);
        pkt(1, 0, 2, 2);
        pkt(2, 0, 2, 2);
        pkt(3, 0, 2, 2);
        pkt(0, 1, 2, 2);
        drive();
        run("s2_done", '0, 60);
        chk("s2_gaps", ov_hist[15:0], 16'h6DB6);
        do_reset();
        pkt(1, 0, 4, 4);
        drive();
        b = 0;
        while (n_out < 2 && b < 20) begin
            step();
            b++;
        end
        out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("s3_rdy", in_ready[1], 0);
            chk("s3_valid", out_valid, 1);
            chk("s3_hold", out_data, wd(1, 0, 2));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        run("s3_done", '0, 20);
        chk("s3_words", n_out, 4);
        do_reset();
        pkt(2, 0, 6, 4);
        drive();
        run("s4_done", '0, 40);
        chk("s4_words", n_out, 4);
        chk("s4_err_cnt", n_err, 1);
        chk("s4_err_time", t_err, t_eop + 1);
        chk("s4_drained", drop_acc, 2);
        do_reset();
        pkt(2, 0, 4, 4);
        drive();
        b = 0;
        while (n_out < 1 && b < 20) begin
            step();
            b++;
        end
        rst = 1'b0;
        #1;
        chk("s5_outs", {in_ready, out_valid, out_sop, out_eop, out_port, busy, err_len}, 0);
        chk("s5_data", out_data, 0);
        for (int i = 0; i < NP; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b1;
        pkt(0, 1, 2, 2);
        pkt(3, 1, 2, 2);
        drive();
        run("s5_done", '0, 30);
        do_reset();
        src_q[1].push_back('{d: wd(1, 9, 0), s: 1'b0, e: 1'b0});
        pkt(2, 0, 2, 2);
        drive();
        run("s6_done", 4'b0010, 30);
        step();
        chk("s6_rdy1", r1_seen, 0);
        chk("s6_stalled", src_q[1].size(), 1);
        chk("s6_idle", busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
